md_unit: RTL and testbench

- Iterative multiply/divide unit for the pipeline CPU; the multi-cycle arithmetic counterpart to the single-cycle ALU.
- Pipeline issues mult/multu/div/divu with operands A, B and a start pulse, stalls on busy, and reads HI/LO after done.
- Shift-add multiply and restoring divide on operand magnitudes, with a final sign fix-up; one result bit per cycle.

---
 rtl/md_unit.sv | 136 +++++++++++++
 tb/tb_md_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Iterative multiply/divide unit: LSB-first shift-add multiply and restoring divide on
// operand magnitudes, one result bit per cycle. Define MD_DIVZERO_EN to add the DivZero flag.
module md_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             Op,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
`ifdef MD_DIVZERO_EN
    output logic             DivZero,
`endif
    output logic [1:0]       dbg_state
);
    // Handshake: start is honoured only in IDLE (busy=0, done=0) and is never queued;
    // busy is high through CALC and FIX; done is a one-cycle pulse while HI/LO hold the new result.

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    localparam int W2 = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             op_r, prod_neg, rem_neg;
    logic [WIDTH-1:0] a_mag, b_mag, acc_hi, acc_lo;
    logic [WIDTH-1:0] a_abs, b_abs, mcand, sub_lo;
    logic [WIDTH:0]   add_sum, shl;
    logic             quo_bit;
    logic [W2-1:0]    prod_fix;

    assign a_abs = (Sign && A[WIDTH-1]) ? ~A + WIDTH'(1) : A;
    assign b_abs = (Sign && B[WIDTH-1]) ? ~B + WIDTH'(1) : B;

    // Multiply: acc_hi:acc_lo is the 2*WIDTH accumulator, multiplier consumed from acc_lo[0].
    assign mcand   = acc_lo[0] ? a_mag : '0;
    assign add_sum = {1'b0, acc_hi} + {1'b0, mcand};

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign shl     = {acc_hi, acc_lo[WIDTH-1]};
    assign quo_bit = (shl >= {1'b0, b_mag});
    assign sub_lo  = shl[WIDTH-1:0] - b_mag;

    assign prod_fix  = prod_neg ? ~{acc_hi, acc_lo} + W2'(1) : {acc_hi, acc_lo};
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            op_r     <= 1'b0;
            prod_neg <= 1'b0;
            rem_neg  <= 1'b0;
            a_mag    <= '0;
            b_mag    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            HI       <= '0;
            LO       <= '0;
`ifdef MD_DIVZERO_EN
            DivZero  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_r     <= Op;
                    prod_neg <= Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                    rem_neg  <= Sign & A[WIDTH-1];
                    a_mag    <= a_abs;
                    b_mag    <= b_abs;
                    acc_hi   <= '0;
                    acc_lo   <= Op ? a_abs : b_abs;
                    cnt      <= '0;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (!op_r) begin
                        acc_hi <= add_sum[WIDTH:1];
                        acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
                    end else begin
                        acc_hi <= quo_bit ? sub_lo : shl[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], quo_bit};
                    end
                end
                FIX: begin
                    if (!op_r) begin
                        {HI, LO} <= prod_fix;
                    end else begin
                        // Zero divisor leaves |A| in the remainder; re-signing it restores raw A.
                        LO <= (b_mag == '0) ? '1 : (prod_neg ? ~acc_lo + WIDTH'(1) : acc_lo);
                        HI <= rem_neg ? ~acc_hi + WIDTH'(1) : acc_hi;
                    end
`ifdef MD_DIVZERO_EN
                    DivZero <= op_r && (b_mag == '0);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases, issue-rule and reset cases, then random
// operations checked against an arithmetic reference model.
module tb_md_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, Op, Sign;
    logic [W-1:0] A, B, HI, LO;
    logic         busy, done;
    logic [1:0]   dbg_state;
`ifdef MD_DIVZERO_EN
    logic         DivZero;
    logic         dz_q[$];
`endif

    logic [2*W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    md_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .Op        (Op),
        .Sign      (Sign),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .HI        (HI),
        .LO        (LO),
`ifdef MD_DIVZERO_EN
        .DivZero   (DivZero),
`endif
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: {HI, LO} straight from the arithmetic definition
    function automatic logic [2*W-1:0] ref_model(input logic op, input logic sign,
                                                 input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [2*W-1:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op) begin
            if (sign) p = sa * sb;
            else      p = {32'h0, a} * {32'h0, b};
            return p;
        end
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (sign) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    function automatic logic [W-1:0] pick();
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 4))
                0: return 32'h0000_0000;
                1: return 32'h0000_0001;
                2: return 32'hFFFF_FFFF;
                3: return 32'h8000_0000;
                default: return 32'h7FFF_FFFF;
            endcase
        end
        return $urandom;
    endfunction

    // driver: called at a negedge; start is held across exactly one rising edge
    task automatic issue(input logic op, input logic sign, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        Op    = op;
        Sign  = sign;
        A     = a;
        B     = b;
        exp_q.push_back(ref_model(op, sign, a, b));
`ifdef MD_DIVZERO_EN
        dz_q.push_back(op && (b == 0));
`endif
        @(negedge clk);
        start = 1'b0;
        Op    = 1'($urandom);
        Sign  = 1'($urandom);
        A     = $urandom;
        B     = $urandom;
    endtask

    // waits for done (bounded), checks result/latency/busy, then steps into the following IDLE cycle
    task automatic collect(input int inject_at, input bit poke_done);
        int edges, busy_n;
        logic [2*W-1:0] exp;
        edges  = 1;
        busy_n = busy ? 1 : 0;
        while (!done && edges < 100) begin
            if (edges == inject_at) begin
                start = 1'b1;
                Op    = 1'($urandom);
                A     = $urandom | 32'h1;
                B     = $urandom | 32'h1;
            end
            @(negedge clk);
            start = 1'b0;
            edges++;
            if (busy) busy_n++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("done_seen", 64'(done), 64'(1));
        check("result", {HI, LO}, exp);
        check("latency_edges", 64'(edges), 64'(34));
        check("busy_cycles", 64'(busy_n), 64'(33));
`ifdef MD_DIVZERO_EN
        if (dz_q.size() > 0) check("divzero", 64'(DivZero), 64'(dz_q.pop_front()));
`endif
        if (poke_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 64'(done), 64'(0));
        check("hold", {HI, LO}, exp);
    endtask

    initial begin
        int  edges;
        logic seen;
        reset = 1'b0;
        start = 1'b0;
        Op    = 1'b0;
        Sign  = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hilo", {HI, LO}, 64'(0));
`ifdef MD_DIVZERO_EN
        check("rst_divzero", 64'(DivZero), 64'(0));
`endif
        reset = 1'b1;
        @(negedge clk);

        // directed cases, issued back-to-back in the IDLE cycle after each DONE
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); collect(-1, 1'b0);
        issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);         collect(-1, 1'b0);
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);         collect(-1, 1'b0);
        issue(1'b1, 1'b0, 32'd100, 32'd7);               collect(-1, 1'b0);
        issue(1'b1, 1'b1, 32'h1234_5678, 32'd0);         collect(-1, 1'b0);
        issue(1'b1, 1'b0, 32'd10, 32'd5);                collect(-1, 1'b0);
        issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF); collect(-1, 1'b0);
        issue(1'b1, 1'b1, 32'h8000_0000, 32'd0);         collect(-1, 1'b0);

        // start during CALC (counter 4, fifth CALC cycle) must be ignored
        issue(1'b0, 1'b0, 32'h0001_2345, 32'h0000_6789); collect(5, 1'b0);

        // start during DONE must be ignored, leaving the unit idle
        issue(1'b1, 1'b0, 32'd1000, 32'd3);              collect(-1, 1'b1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | busy | done;
        end
        check("done_start_ignored", 64'(seen), 64'(0));
        check("idle_hold", {HI, LO}, {32'd1, 32'd333});

        // asynchronous reset in the middle of CALC (counter = 10)
        issue(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0123_4567);
        void'(exp_q.pop_back());
`ifdef MD_DIVZERO_EN
        void'(dz_q.pop_back());
`endif
        edges = 1;
        while (edges < 11) begin
            @(negedge clk);
            edges++;
        end
        reset = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_hilo", {HI, LO}, 64'(0));
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            seen = seen | busy | done;
        end
        check("no_done_after_rst", 64'(seen), 64'(0));

        // random operations
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic rop, rsg;
            ra  = pick();
            rb  = pick();
            rop = 1'($urandom_range(0, 1));
            rsg = 1'($urandom_range(0, 1));
            issue(rop, rsg, ra, rb);
            collect(-1, 1'b0);
        end

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
